// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage
//   MEM->WB pipeline stage. It holds the load data, the ALU result, the
//   destination register and the write-back controls of one instruction
//   (or two, when the skid buffer is enabled). It adds a valid/ready
//   handshake, a synchronous flush, x0 write suppression and a saturating
//   stall counter.
//
// Handshake: an entry moves on a rising edge where valid & ready are both
//   high. in_valid/in_* and out_valid/out_* are held stable by their
//   producer until accepted. in_ready/out_ready may change at any time
//   (in_ready only at clock edges when SKID = 1).
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               synchronous: drops every held entry
//   in_valid/in_ready   upstream handshake
//   in_data, in_alu     memory read data / ALU result (DATA_W)
//   in_rd               destination register (RD_W)
//   in_mem_to_reg       1 selects data, 0 selects alu at write-back
//   in_reg_write_en     register write request
//   out_valid/out_ready write-back handshake for the head entry
//   out_data, out_alu, out_rd, out_mem_to_reg, out_reg_write_en
//                       head entry (controls gated low when out_valid = 0)
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
module wb_pipe_stage #(
   parameter int DATA_W         = 64,
   parameter int RD_W           = 5,
   parameter int SKID           = 1,
   parameter int ZERO_RD_SQUASH = 1,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_mem_to_reg,
   input  logic              in_reg_write_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] out_alu,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_mem_to_reg,
   output logic              out_reg_write_en,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] alu;
      logic [RD_W-1:0]   rd;
      logic              mem_to_reg;
      logic              reg_write_en;
   } entry_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   entry_t in_entry;
   entry_t head_q;
   logic   head_valid;
   logic   do_accept;
   logic   do_release;

   // The x0 squash is applied once, when the entry is captured, so the
   // stored control already reflects it.
   always_comb begin
      in_entry              = '0;
      in_entry.data         = in_data;
      in_entry.alu          = in_alu;
      in_entry.rd           = in_rd;
      in_entry.mem_to_reg   = in_mem_to_reg;
      in_entry.reg_write_en = in_reg_write_en &
                              ((ZERO_RD_SQUASH == 0) || (in_rd != '0));
   end

   assign do_accept  = in_valid & in_ready;
   assign do_release = head_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

         state_t state_q;
         entry_t skid_q;
         logic   ready_q;

         // Occupancy FSM. The head register always holds the oldest entry;
         // the skid register only ever holds the second one.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_q <= S_EMPTY;
               head_q  <= '0;
               skid_q  <= '0;
               ready_q <= 1'b1;
            end else if (flush) begin
               state_q <= S_EMPTY;
               ready_q <= 1'b1;
            end else begin
               case (state_q)
                  S_EMPTY: begin
                     if (do_accept) begin
                        head_q  <= in_entry;
                        state_q <= S_ONE;
                     end
                  end
                  S_ONE: begin
                     if (do_accept && do_release) begin
                        head_q <= in_entry;
                     end else if (do_accept) begin
                        skid_q  <= in_entry;
                        state_q <= S_FULL;
                        ready_q <= 1'b0;
                     end else if (do_release) begin
                        state_q <= S_EMPTY;
                     end
                  end
                  S_FULL: begin
                     // in_ready is low here, so no accept can coincide.
                     if (do_release) begin
                        head_q  <= skid_q;
                        state_q <= S_ONE;
                        ready_q <= 1'b1;
                     end
                  end
                  default: begin
                     state_q <= S_EMPTY;
                     ready_q <= 1'b1;
                  end
               endcase
            end
         end

         assign head_valid = (state_q != S_EMPTY);
         assign in_ready   = ready_q;
      end else begin : g_single
         logic valid_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid_q <= 1'b0;
               head_q  <= '0;
            end else if (flush) begin
               valid_q <= 1'b0;
            end else if (do_accept) begin
               // Covers the accept-with-release case: the head is replaced.
               head_q  <= in_entry;
               valid_q <= 1'b1;
            end else if (do_release) begin
               valid_q <= 1'b0;
            end
         end

         assign head_valid = valid_q;
         assign in_ready   = !valid_q | out_ready;
      end
   endgenerate

   // Stall counter: only reset clears it; flush leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (head_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   assign out_valid        = head_valid;
   assign out_data         = head_q.data;
   assign out_alu          = head_q.alu;
   assign out_rd           = head_q.rd;
   assign out_mem_to_reg   = head_valid & head_q.mem_to_reg;
   assign out_reg_write_en = head_valid & head_q.reg_write_en;

endmodule
